wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master Wishbone classic arbiter, round-robin, ownership held for a whole bus cycle.
// Define WB_ARB_TIMEOUT_EN to build the stall watchdog (TIMEOUT_CYCLES applies only then).
module wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last, last_nxt;
    logic   wd_fire;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // last records the previous owner, so a tie goes to the other master
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_nxt = last ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_nxt = OWN0;
                else if (m1_cyc_i)        state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_nxt = IDLE;
                    last_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (state)
            OWN0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~wd_fire;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i | wd_fire;
                m0_rty_o = s_rty_i;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~wd_fire;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i | wd_fire;
                m1_rty_o = s_rty_i;
            end
            default: ;
        endcase
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = {state == OWN1, state == OWN0};

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] wd_cnt;
    logic        s_term;

    assign s_term    = s_ack_i | s_err_i | s_rty_i;
    assign wd_fire   = (wd_cnt == TIMEOUT_LIMIT);
    assign timeout_o = wd_fire;

    // A firing cycle forces s_stb_o low, so the counter restarts from zero after it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   wd_cnt <= '0;
        else if (state_nxt == IDLE || wd_fire || s_term) wd_cnt <= '0;
        else if (s_stb_o)                              wd_cnt <= wd_cnt + 16'd1;
    end
`else
    logic timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign wd_fire        = 1'b0;
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level ownership model. Works with WB_ARB_TIMEOUT_EN defined or not.
module tb_wb_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_ack, s_err, s_rty;
    logic [1:0]  grant;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    // Model: owner 0 = none, 1 = master 0, 2 = master 1; last = index of previous owner
    int m_owner, m_last, m_stall;

    always #5 clk = ~clk;

    wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_rdat),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_rdat),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_sel_o(s_sel), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant), .timeout_o(timeout)
    );

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat = '0;
        s_rdat = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_owner = 0;
        m_last  = 1;
        m_stall = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        m0_cyc = 1; m1_cyc = 1; m0_stb = 1; m1_stb = 1; s_ack = 1;
        @(negedge clk);
        #1;
        total++;
        if ({grant, s_cyc, s_stb, timeout, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== 11'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0", {grant, s_cyc, s_stb, timeout,
                     m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty});
        end
        do_reset();
        #1;
        total++;
        if ({grant, s_cyc, s_stb, timeout} !== 5'b0) begin
            bad++;
            $display("FAIL reset_release got=%b want=00000", {grant, s_cyc, s_stb, timeout});
        end
    endtask

    task automatic test_single();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h0000_0100; m0_sel = 4'hF;
        #1;
        total++;
        if ({grant, s_cyc} !== 3'b000) begin
            bad++;
            $display("FAIL single_latency got=%b want=000", {grant, s_cyc});
        end
        tick(); #1;
        total++;
        if ({grant, s_cyc, s_stb, s_we, s_adr, s_sel} !== {2'b01, 3'b110, 32'h0000_0100, 4'hF}) begin
            bad++;
            $display("FAIL single_route got=%h want=%h", {grant, s_cyc, s_stb, s_we, s_adr, s_sel},
                     {2'b01, 3'b110, 32'h0000_0100, 4'hF});
        end
        total++;
        if (m0_ack !== 1'b0) begin
            bad++;
            $display("FAIL single_noack got=%b want=0", m0_ack);
        end
        s_ack = 1; s_rdat = 32'hDEAD_BEEF;
        #1;
        total++;
        if ({m0_ack, m0_rdat, m1_ack} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            bad++;
            $display("FAIL single_ack got=%h want=%h", {m0_ack, m0_rdat, m1_ack}, {1'b1, 32'hDEAD_BEEF, 1'b0});
        end
        tick();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        tick(); #1;
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL single_release got=%b want=00", grant);
        end
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        tick(); #1;
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL tie_first got=%b want=01", grant);
        end
        m0_cyc = 0;
        tick(); #1;
        total++;
        if ({grant, s_cyc} !== 3'b000) begin
            bad++;
            $display("FAIL tie_idle got=%b want=000", {grant, s_cyc});
        end
        tick(); #1;
        total++;
        if (grant !== 2'b10) begin
            bad++;
            $display("FAIL tie_handover got=%b want=10", grant);
        end
        m1_cyc = 0;
        tick();
        m0_cyc = 1; m1_cyc = 1;
        tick(); #1;
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL tie_repeat got=%b want=01", grant);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_hold();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_sel = 4'h3;
        tick();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        for (int i = 0; i < 3; i++) begin
            m1_adr = 32'h0000_2000 + 32'(i * 4);
            #1;
            total++;
            if ({grant, m1_ack, m0_ack, s_adr} !== {2'b10, 2'b10, m1_adr}) begin
                bad++;
                $display("FAIL hold_strobe%0d got=%h want=%h", i, {grant, m1_ack, m0_ack, s_adr},
                         {2'b10, 2'b10, m1_adr});
            end
            tick();
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        tick(); #1;
        total++;
        if (grant !== 2'b00) begin
            bad++;
            $display("FAIL hold_idle got=%b want=00", grant);
        end
        tick(); #1;
        total++;
        if ({grant, s_cyc, s_stb} !== 4'b0111) begin
            bad++;
            $display("FAIL hold_next got=%b want=0111", {grant, s_cyc, s_stb});
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0040;
        tick();
`ifdef WB_ARB_TIMEOUT_EN
        for (int i = 1; i <= TO; i++) begin
            #1;
            total++;
            if ({timeout, m0_err, s_stb} !== 3'b001) begin
                bad++;
                $display("FAIL wd_wait%0d got=%b want=001", i, {timeout, m0_err, s_stb});
            end
            tick();
        end
        #1;
        total++;
        if ({timeout, m0_err, s_stb, grant} !== 5'b11001) begin
            bad++;
            $display("FAIL wd_fire got=%b want=11001", {timeout, m0_err, s_stb, grant});
        end
        tick(); #1;
        total++;
        if ({timeout, m0_err, s_stb, grant} !== 5'b00101) begin
            bad++;
            $display("FAIL wd_rearm got=%b want=00101", {timeout, m0_err, s_stb, grant});
        end
`else
        for (int i = 1; i <= 20; i++) begin
            #1;
            total++;
            if ({timeout, m0_err, s_stb, grant} !== 5'b00101) begin
                bad++;
                $display("FAIL stall%0d got=%b want=00101", i, {timeout, m0_err, s_stb, grant});
            end
            tick();
        end
`endif
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_cyc = 1; m1_stb = 1;
        tick(); #1;
        total++;
        if ({grant, s_cyc, s_stb} !== 4'b1011) begin
            bad++;
            $display("FAIL rstmid_own got=%b want=1011", {grant, s_cyc, s_stb});
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({grant, s_cyc, s_stb} !== 4'b0000) begin
            bad++;
            $display("FAIL rstmid_async got=%b want=0000", {grant, s_cyc, s_stb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        m0_cyc = 1;
        tick(); #1;
        total++;
        if (grant !== 2'b01) begin
            bad++;
            $display("FAIL rstmid_tie got=%b want=01", grant);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  exp_grant;
        logic        own_cyc, own_stb, own_we, fire, term;
        logic [31:0] own_adr, own_dat;
        logic [3:0]  own_sel;
        logic [5:0]  exp_term;
        int          nxt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            m0_cyc = m0_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            m1_cyc = m1_cyc ? ($urandom_range(7) != 0) : ($urandom_range(3) == 0);
            m0_stb = m0_cyc && ($urandom_range(3) != 0);
            m1_stb = m1_cyc && ($urandom_range(3) != 0);
            m0_we  = 1'($urandom); m1_we  = 1'($urandom);
            m0_adr = $urandom;     m1_adr = $urandom;
            m0_sel = 4'($urandom); m1_sel = 4'($urandom);
            m0_dat = $urandom;     m1_dat = $urandom;
            s_rdat = $urandom;
            s_ack  = ($urandom_range(2) == 0);
            s_err  = ($urandom_range(15) == 0);
            s_rty  = ($urandom_range(15) == 0);
            #1;
`ifdef WB_ARB_TIMEOUT_EN
            fire = (m_owner != 0) && (m_stall == TO);
`else
            fire = 1'b0;
`endif
            own_cyc = 0; own_stb = 0; own_we = 0; own_adr = '0; own_sel = '0; own_dat = '0;
            if (m_owner == 1) begin
                own_cyc = m0_cyc; own_stb = m0_stb; own_we = m0_we;
                own_adr = m0_adr; own_sel = m0_sel; own_dat = m0_dat;
            end else if (m_owner == 2) begin
                own_cyc = m1_cyc; own_stb = m1_stb; own_we = m1_we;
                own_adr = m1_adr; own_sel = m1_sel; own_dat = m1_dat;
            end
            own_stb   = own_stb && !fire;
            exp_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
            exp_term  = '0;
            if (m_owner == 1) exp_term[5:3] = {s_ack, s_err || fire, s_rty};
            if (m_owner == 2) exp_term[2:0] = {s_ack, s_err || fire, s_rty};

            total++;
            if ({grant, s_cyc, s_stb, timeout} !== {exp_grant, own_cyc, own_stb, fire}) begin
                bad++;
                $display("FAIL rnd%0d_ctrl got=%b want=%b", n, {grant, s_cyc, s_stb, timeout},
                         {exp_grant, own_cyc, own_stb, fire});
            end
            if (m_owner != 0) begin
                total++;
                if ({s_we, s_adr, s_sel, s_wdat} !== {own_we, own_adr, own_sel, own_dat}) begin
                    bad++;
                    $display("FAIL rnd%0d_route got=%h want=%h", n, {s_we, s_adr, s_sel, s_wdat},
                             {own_we, own_adr, own_sel, own_dat});
                end
            end
            total++;
            if ({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty} !== exp_term) begin
                bad++;
                $display("FAIL rnd%0d_term got=%b want=%b", n,
                         {m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}, exp_term);
            end
            total++;
            if ({m0_rdat, m1_rdat} !== {s_rdat, s_rdat}) begin
                bad++;
                $display("FAIL rnd%0d_rdata got=%h want=%h", n, {m0_rdat, m1_rdat}, {s_rdat, s_rdat});
            end

            // Ownership: hold while own cyc stays high, otherwise release, tie goes to the non-last master
            nxt = m_owner;
            if (m_owner == 0) begin
                if (m0_cyc && m1_cyc) nxt = (m_last == 0) ? 2 : 1;
                else if (m0_cyc)      nxt = 1;
                else if (m1_cyc)      nxt = 2;
            end else if (m_owner == 1 && !m0_cyc) begin
                nxt = 0; m_last = 0;
            end else if (m_owner == 2 && !m1_cyc) begin
                nxt = 0; m_last = 1;
            end
            term = s_ack || s_err || s_rty;
            if (nxt == 0 || fire || term) m_stall = 0;
            else if (own_stb)             m_stall = m_stall + 1;
            m_owner = nxt;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL bench_timeout got=running want=finished");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        clear_inputs();
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_tie();
        test_hold();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
